// File: rtl/rf_port_arbiter_if.sv
// Write-port bundle between two requesters, the arbiter and the register file.
// Latency: none (wires only); the arbiter registers every output it drives.
// Backpressure: requesters hold req/dest/data until their gnt pulse is seen.
// Optional macro RF_WR_COUNT_EN adds the per-requester write counters.
interface rf_port_arbiter_if #(
    parameter int W = 8
);
    // requester 0
    logic         req0;
    logic [3:0]   dest0;
    logic [W-1:0] data0;
    logic         gnt0;
    // requester 1
    logic         req1;
    logic [3:0]   dest1;
    logic [W-1:0] data1;
    logic         gnt1;
    // register file write port
    logic         rf_wrt_enable;
    logic [3:0]   rf_dest_sel;
    logic [W-1:0] rf_wrt_data;
    logic         init_done;
`ifdef RF_WR_COUNT_EN
    logic [15:0]  wr_count0;
    logic [15:0]  wr_count1;
`endif

    // arbiter side
    modport slave (
        input  req0, dest0, data0,
        input  req1, dest1, data1,
        output gnt0, gnt1,
        output rf_wrt_enable, rf_dest_sel, rf_wrt_data,
        output init_done
`ifdef RF_WR_COUNT_EN
        , output wr_count0, wr_count1
`endif
    );

    // requester / register-file side
    modport master (
        output req0, dest0, data0,
        output req1, dest1, data1,
        input  gnt0, gnt1,
        input  rf_wrt_enable, rf_dest_sel, rf_wrt_data,
        input  init_done
`ifdef RF_WR_COUNT_EN
        , input wr_count0, wr_count1
`endif
    );
endinterface

// File: rtl/rf_port_arbiter.sv
// Clears the register file after reset, then shares its single write port round-robin.
// Latency: req sampled at edge E -> gnt + write strobe registered out after E, RF writes at E+1.
// Backpressure: a requester holds req/dest/data until gnt; granted side is masked one arbitration.
// Optional macro RF_WR_COUNT_EN adds saturating per-requester grant counters.
module rf_port_arbiter #(
    parameter int W    = 8,
    parameter int NREG = 16   // registers cleared at init, at most 16 (4-bit address)
) (
    input  logic            clock,
    input  logic            rst,     // asynchronous, active low
    rf_port_arbiter_if.slave bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    // idx needs one extra bit so it can reach NREG (the "clear finished" step)
    localparam logic [4:0] NREG_L = 5'(NREG);

    state_t       state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic         rr_q, rr_d;          // 0: requester 0 wins a tie, 1: requester 1 wins
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic         wen_q, wen_d;
    logic [3:0]   dest_q, dest_d;
    logic [W-1:0] data_q, data_d;
    logic         done_q, done_d;

    // a requester granted last cycle is still presenting the stale request,
    // so the previous grant pulse doubles as its one-arbitration mask
    logic         elig0, elig1;
    logic         pick0, pick1;

    // eligibility and round-robin choice for the ARB state
    always_comb begin
        elig0 = bus.req0 & ~gnt0_q;
        elig1 = bus.req1 & ~gnt1_q;
        pick0 = elig0 & (~elig1 | ~rr_q);
        pick1 = elig1 & ~pick0;
    end

    // next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        wen_d   = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        done_d  = done_q;

        case (state_q)
            ST_INIT: begin
                if (idx_q < NREG_L) begin
                    // one clearing write per cycle, requests ignored
                    wen_d  = 1'b1;
                    dest_d = idx_q[3:0];
                    data_d = '0;
                    idx_d  = idx_q + 5'd1;
                end else begin
                    // write port idles for one cycle while init_done rises
                    done_d  = 1'b1;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick0) begin
                    gnt0_d = 1'b1;
                    wen_d  = 1'b1;
                    dest_d = bus.dest0;
                    data_d = bus.data0;
                    rr_d   = 1'b1;
                end else if (pick1) begin
                    gnt1_d = 1'b1;
                    wen_d  = 1'b1;
                    dest_d = bus.dest1;
                    data_d = bus.data1;
                    rr_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            rr_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            wen_q   <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            wen_q   <= wen_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.gnt0          = gnt0_q;
    assign bus.gnt1          = gnt1_q;
    assign bus.rf_wrt_enable = wen_q;
    assign bus.rf_dest_sel   = dest_q;
    assign bus.rf_wrt_data   = data_q;
    assign bus.init_done     = done_q;

`ifdef RF_WR_COUNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // count grants as they are issued (INIT never grants), saturating at all-ones
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0_d && (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (gnt1_d && (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    // counter registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.wr_count0 = cnt0_q;
    assign bus.wr_count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter: scoreboard of expected register-file writes.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
// Optional macro RF_WR_COUNT_EN enables the write-counter checks.
module tb_rf_port_arbiter;

    typedef struct packed {
        logic [3:0] dest;
        logic [7:0] data;
        logic       g0;
        logic       g1;
    } exp_t;

    logic clock;
    logic rst;
    int   nchk  = 0;
    int   npass = 0;
    int   nfail = 0;
    int   g0cnt = 0;
    int   g1cnt = 0;
    bit   drop0 = 0;
    bit   drop1 = 0;
    exp_t sb[$];
    logic [7:0] rfm [16];

    rf_port_arbiter_if #(.W(8)) bus ();

    rf_port_arbiter #(.W(8), .NREG(16)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // register-file model written by the arbiter's port
    always @(posedge clock) begin
        if (bus.rf_wrt_enable === 1'b1) rfm[bus.rf_dest_sel] <= bus.rf_wrt_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic [7:0] v, input logic g0, input logic g1);
        exp_t e;
        e.dest = d; e.data = v; e.g0 = g0; e.g1 = g1;
        sb.push_back(e);
    endtask

    // advance one cycle, score any write, emulate requesters that drop after gnt
    task automatic cycle();
        exp_t e;
        @(posedge clock);
        #1;
        if (bus.gnt0 === 1'b1) g0cnt++;
        if (bus.gnt1 === 1'b1) g1cnt++;
        if (bus.rf_wrt_enable !== 1'b0) begin
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_dest", 32'(bus.rf_dest_sel), 32'(e.dest));
                check("wr_data", 32'(bus.rf_wrt_data), 32'(e.data));
                check("wr_gnt0", 32'(bus.gnt0), 32'(e.g0));
                check("wr_gnt1", 32'(bus.gnt1), 32'(e.g1));
            end
        end
        if (drop0 && bus.gnt0 === 1'b1) bus.req0 = 1'b0;
        if (drop1 && bus.gnt1 === 1'b1) bus.req1 = 1'b0;
    endtask

    // release reset (caller is away from an edge) and score the 16 clearing writes
    task automatic run_init();
        for (int i = 0; i < 16; i++) push(4'(i), 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            cycle();
            if (c <= 16) check("init_wen", 32'(bus.rf_wrt_enable), 32'd1);
            if (c == 16) check("init_done_early", 32'(bus.init_done), 32'd0);
            if (c == 17) begin
                check("init_done", 32'(bus.init_done), 32'd1);
                check("init_idle", 32'(bus.rf_wrt_enable), 32'd0);
            end
        end
        check("init_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    int base;
    int wcnt;

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0; bus.dest0 = 4'd0; bus.data0 = 8'h00;
        bus.req1 = 1'b0; bus.dest1 = 4'd0; bus.data1 = 8'h00;

        // reset state
        @(posedge clock); @(posedge clock); #1;
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check("rst_gnt1", 32'(bus.gnt1), 32'd0);
        check("rst_wen", 32'(bus.rf_wrt_enable), 32'd0);
        check("rst_dest", 32'(bus.rf_dest_sel), 32'd0);
        check("rst_data", 32'(bus.rf_wrt_data), 32'd0);
        check("rst_done", 32'(bus.init_done), 32'd0);

        // clear sequence with no requests
        run_init();
        for (int i = 0; i < 16; i++) check("rf_cleared", 32'(rfm[i]), 32'd0);

        // single request, dropped after its grant
        drop0 = 1; drop1 = 1;
        base = g0cnt;
        bus.req0 = 1'b1; bus.dest0 = 4'd3; bus.data0 = 8'hA5;
        push(4'd3, 8'hA5, 1'b1, 1'b0);
        cycle();
        check("single_latency", 32'(bus.gnt0), 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        check("single_pulses", 32'(g0cnt - base), 32'd1);
        check("rf_reg3", 32'(rfm[3]), 32'hA5);

        // both held: pointer favours requester 1 after the last gnt0
        drop0 = 0; drop1 = 0;
        bus.req0 = 1'b1; bus.dest0 = 4'd1; bus.data0 = 8'h11;
        bus.req1 = 1'b1; bus.dest1 = 4'd2; bus.data1 = 8'h22;
        for (int i = 0; i < 3; i++) begin
            push(4'd2, 8'h22, 1'b0, 1'b1);
            push(4'd1, 8'h11, 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("both_busy", 32'(bus.rf_wrt_enable), 32'd1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle();
        check("idle_wen", 32'(bus.rf_wrt_enable), 32'd0);
        check("idle_dest_hold", 32'(bus.rf_dest_sel), 32'd1);
        check("idle_data_hold", 32'(bus.rf_wrt_data), 32'h11);
        check("both_sb_empty", 32'(sb.size()), 32'd0);

        // requester 0 held alone: granted every other cycle
        bus.req0 = 1'b1; bus.dest0 = 4'd4; bus.data0 = 8'h44;
        for (int i = 0; i < 4; i++) push(4'd4, 8'h44, 1'b1, 1'b0);
        wcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("alone_gnt0", 32'(bus.gnt0), 32'((i % 2) == 0));
            if (bus.rf_wrt_enable === 1'b1) wcnt++;
        end
        check("alone_duty", 32'(wcnt), 32'd4);
        bus.req0 = 1'b0;
        cycle();
        check("alone_sb_empty", 32'(sb.size()), 32'd0);

        // same destination from both: grant order 1 then 0, last write wins
        drop0 = 1; drop1 = 1;
        bus.req0 = 1'b1; bus.dest0 = 4'd5; bus.data0 = 8'h10;
        bus.req1 = 1'b1; bus.dest1 = 4'd5; bus.data1 = 8'h20;
        push(4'd5, 8'h20, 1'b0, 1'b1);
        push(4'd5, 8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        check("same_dest_last", 32'(rfm[5]), 32'h10);
        check("same_sb_empty", 32'(sb.size()), 32'd0);

        // reset in the middle of INIT at index 7
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) push(4'(i), 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle();
        check("mid_init_dest", 32'(bus.rf_dest_sel), 32'd7);
        rst = 1'b0;
        #1;
        check("midrst_wen", 32'(bus.rf_wrt_enable), 32'd0);
        check("midrst_dest", 32'(bus.rf_dest_sel), 32'd0);
        check("midrst_done", 32'(bus.init_done), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        // a request held through INIT is only granted once arbitration starts
        drop1 = 1;
        bus.req1 = 1'b1; bus.dest1 = 4'd9; bus.data1 = 8'h99;
        run_init();
        push(4'd9, 8'h99, 1'b0, 1'b1);
        cycle();
        check("post_init_gnt1", 32'(bus.gnt1), 32'd1);
        cycle();
        check("post_init_sb_empty", 32'(sb.size()), 32'd0);

`ifdef RF_WR_COUNT_EN
        // counters: fresh reset, 3 grants to requester 0 and 5 to requester 1
        rst = 1'b0;
        #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drop0 = 0; drop1 = 0;
        run_init();
        check("cnt0_after_init", 32'(bus.wr_count0), 32'd0);
        check("cnt1_after_init", 32'(bus.wr_count1), 32'd0);
        bus.req0 = 1'b1; bus.dest0 = 4'd6; bus.data0 = 8'h66;
        bus.req1 = 1'b1; bus.dest1 = 4'd7; bus.data1 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            push(4'd6, 8'h66, 1'b1, 1'b0);
            push(4'd7, 8'h77, 1'b0, 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle();
        bus.req0 = 1'b0;
        push(4'd7, 8'h77, 1'b0, 1'b1);
        push(4'd7, 8'h77, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        bus.req1 = 1'b0;
        cycle(); cycle();
        check("cnt0", 32'(bus.wr_count0), 32'd3);
        check("cnt1", 32'(bus.wr_count1), 32'd5);
        check("cnt_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
